// File: rtl/mem_march_bist.sv
// March C- BIST controller for a 32 x 8 zero-latency register file.
// Runs M0..M5 over all words and reports pass, error count and first failing location.
module mem_march_bist #(
  parameter logic [7:0] BG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       mem_we,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [4:0] fail_addr,
  output logic [2:0] fail_elem,
  output logic [7:0] fail_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic       op_q, op_d;
  logic [4:0] addr_q, addr_d;
  logic       first_q, first_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [4:0] fail_addr_q, fail_addr_d;
  logic [2:0] fail_elem_q, fail_elem_d;
  logic [7:0] fail_data_q, fail_data_d;
  logic       mem_we_q, mem_we_d;
  logic [4:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       mismatch;
  logic [7:0] exp_val;

  // Element table: M0 (w0) | M1..M4 (r, w) | M5 (r0); op 1 is always the write.
  function automatic logic op_is_write(input logic [2:0] e, input logic op);
    return (e == 3'd0) || (op && (e >= 3'd1) && (e <= 3'd4));
  endfunction

  function automatic logic op_value(input logic [2:0] e, input logic op);
    return op ? ((e == 3'd1) || (e == 3'd3)) : ((e == 3'd2) || (e == 3'd4));
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic last_op(input logic [2:0] e, input logic op);
    return (e == 3'd0) || (e == 3'd5) || op;
  endfunction

  assign exp_val  = op_value(elem_q, op_q) ? ~BG : BG;
  assign mismatch = (state_q == S_RUN) && !op_is_write(elem_q, op_q) && (mem_rdata != exp_val);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    first_d     = first_q;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          op_d        = 1'b0;
          addr_d      = 5'd0;
          first_d     = 1'b0;
          err_d       = 8'd0;
          pass_d      = 1'b0;
          fail_addr_d = 5'd0;
          fail_elem_d = 3'd0;
          fail_data_d = 8'd0;
        end
      end
      S_RUN: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!first_q) begin
            first_d     = 1'b1;
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
            fail_data_d = mem_rdata;
          end
        end
        if (abort) begin
          state_d = S_IDLE;
          elem_d  = 3'd0;
          op_d    = 1'b0;
          addr_d  = 5'd0;
        end else if (!last_op(elem_q, op_q)) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (addr_q == (elem_down(elem_q) ? 5'd0 : 5'd31)) begin
            if (elem_q == 3'd5) begin
              state_d = S_DONE;
              elem_d  = 3'd0;
              addr_d  = 5'd0;
              pass_d  = (err_d == 8'd0);
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = elem_down(elem_q + 3'd1) ? 5'd31 : 5'd0;
            end
          end else begin
            addr_d = elem_down(elem_q) ? addr_q - 5'd1 : addr_q + 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line up with the op.
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    mem_we_d    = busy_d && op_is_write(elem_d, op_d);
    mem_addr_d  = busy_d ? addr_d : 5'd0;
    mem_wdata_d = mem_we_d ? (op_value(elem_d, op_d) ? ~BG : BG) : 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      op_q        <= 1'b0;
      addr_q      <= 5'd0;
      first_q     <= 1'b0;
      err_q       <= 8'd0;
      pass_q      <= 1'b0;
      fail_addr_q <= 5'd0;
      fail_elem_q <= 3'd0;
      fail_data_q <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 5'd0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;

endmodule
